// File: rtl/if_pkg.sv
// Fetch-stage shared types and default widths.
// Imported by the fetch unit, its interface and its FIFOs.
package if_pkg;

  localparam int IF_ADDR_W  = 9;
  localparam int IF_INST_W  = 32;
  localparam int IF_DEPTH   = 2;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus.
// master = fetch unit, slave = instruction memory.
interface inst_fetch_if
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int INST_W = IF_INST_W
);

  logic              imem_req;
  logic [ADDR_W-1:0] imem_adrx;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [INST_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_adrx,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_adrx,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_fifo.sv
// Small synchronous FIFO with a clear input.
// Push while full is taken only when a pop frees the slot.
module if_fifo
  import if_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_clr,
  input  logic                   i_push,
  input  logic [W-1:0]           i_din,
  input  logic                   i_pop,
  output logic [W-1:0]           o_dout,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_cnt;

  logic w_wr;
  logic w_rd;

  assign w_rd = i_pop && (r_cnt != '0);
  assign w_wr = i_push && ((r_cnt != FULL) || w_rd);

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_clr) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= i_din;
        r_wp        <= r_wp + 1'b1;
      end
      if (w_rd) begin
        r_rp <= r_rp + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues imem reads from pc, tags them,
// and queues returned words in order for decode.
module inst_fetch
  import if_pkg::*;
#(
  parameter int ADDR_W = IF_ADDR_W,
  parameter int INST_W = IF_INST_W,
  parameter int DEPTH  = IF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              fetch_stall,
  inst_fetch_if.master      imem,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CAP = CW'(DEPTH);
  localparam int BW = INST_W + ADDR_W;

  fetch_state_e r_state;
  logic         r_live;
  logic [CW-1:0] r_drop;

  logic [CW-1:0] w_out;
  logic [CW-1:0] w_cnt;
  logic [CW-1:0] w_avail;
  logic [CW-1:0] w_out_n;
  logic [CW-1:0] w_cnt_n;
  logic [CW-1:0] w_sum_n;
  logic [CW-1:0] w_drop_n;

  logic w_credit;
  logic w_req;
  logic w_grant;
  logic w_rv;
  logic w_keep;
  logic w_pop;

  logic [ADDR_W-1:0] w_tag;
  logic [BW-1:0]     w_head;

  assign inst_valid = (w_cnt != '0);
  assign {inst, inst_pc} = w_head;

  assign w_pop  = inst_valid && inst_ready && !flush;
  assign w_rv   = imem.imem_rvalid && (w_out != '0);
  assign w_keep = w_rv && (r_drop == '0) && !flush;

  // a head leaving this cycle already frees its slot
  assign w_avail  = w_cnt - CW'(w_pop) + w_out;
  assign w_credit = (w_avail < CAP);

  assign w_req = r_live
              && (r_state != DRAIN)
              && w_credit
              && !flush;

  assign w_grant = w_req && imem.imem_gnt;

  assign imem.imem_req  = w_req;
  assign imem.imem_adrx = w_req ? pc : '0;
  assign fetch_stall    = !w_grant;

  assign w_out_n = w_out + CW'(w_grant) - CW'(w_rv);
  assign w_cnt_n = flush ? '0
                 : w_cnt + CW'(w_keep) - CW'(w_pop);
  assign w_sum_n = w_out_n + w_cnt_n;

  always_comb begin
    w_drop_n = r_drop;
    if (flush) begin
      w_drop_n = w_out - CW'(w_rv);
    end else if (w_rv && (r_drop != '0)) begin
      w_drop_n = r_drop - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_drop  <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      r_drop <= w_drop_n;
      if (w_drop_n != '0) begin
        r_state <= DRAIN;
      end else if (w_sum_n < CAP) begin
        r_state <= RUN;
      end else begin
        r_state <= WAIT;
      end
    end
  end

  // tag FIFO depth equals outstanding-read count
  if_fifo #(
    .W     (ADDR_W),
    .DEPTH (DEPTH)
  ) u_tag (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (1'b0),
    .i_push  (w_grant),
    .i_din   (pc),
    .i_pop   (w_rv),
    .o_dout  (w_tag),
    .o_count (w_out)
  );

  if_fifo #(
    .W     (BW),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (flush),
    .i_push  (w_keep),
    .i_din   ({imem.imem_rdata, w_tag}),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_count (w_cnt)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: vector table plus
// hand sequences for flush, drain and reset.
module tb_inst_fetch;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  pc;
  logic        flush;
  logic        fetch_stall;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [8:0]  inst_pc;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [8:0] mq [$];

  typedef struct packed {
    logic       g;
    logic       r;
    logic       req;
    logic [8:0] a;
    logic       s;
    logic       v;
    logic [8:0] ip;
  } vec_t;

  vec_t tbl [14];

  inst_fetch_if #(.ADDR_W(9), .INST_W(32)) bus ();

  inst_fetch #(
    .ADDR_W (9),
    .INST_W (32),
    .DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .flush       (flush),
    .fetch_stall (fetch_stall),
    .imem        (bus),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [8:0] a);
    return 32'hA000_0000 | {23'd0, a};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL c%0d %s: got %h want %h", cyc, nm, act, exp);
    end
  endtask

  task automatic step(input logic g, input logic r,
                      input logic rsp, input logic fl,
                      input logic ereq, input logic [8:0] ea,
                      input logic es, input logic ev,
                      input logic [8:0] ei);
    logic adv;
    bus.imem_gnt = g;
    inst_ready   = r;
    flush        = fl;
    if (rsp && mq.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = dat(mq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
    end
    #2;
    chk("req", 32'(bus.imem_req), 32'(ereq));
    if (ereq) chk("adrx", 32'(bus.imem_adrx), 32'(ea));
    chk("stall", 32'(fetch_stall), 32'(es));
    chk("ivalid", 32'(inst_valid), 32'(ev));
    if (ev) begin
      chk("inst_pc", 32'(inst_pc), 32'(ei));
      chk("inst", inst, dat(ei));
    end
    if (bus.imem_req && bus.imem_gnt) mq.push_back(bus.imem_adrx);
    adv = !fetch_stall;
    @(posedge clk);
    #1;
    if (adv) pc = pc + 9'(INST_BYTES);
    cyc++;
  endtask

  task automatic hs(input logic g, input logic r,
                    input logic rsp, input logic fl,
                    input logic ereq, input logic [8:0] ea,
                    input logic ev, input logic [8:0] ei);
    step(g, r, rsp, fl, ereq, ea, !(ereq && g), ev, ei);
  endtask

  initial begin
    //            g    r    req  adrx    stl  v    inst_pc
    tbl[0]  = '{1'b1,1'b1,1'b0,9'h000,1'b1,1'b0,9'h000};
    tbl[1]  = '{1'b1,1'b1,1'b1,9'h000,1'b0,1'b0,9'h000};
    tbl[2]  = '{1'b1,1'b1,1'b1,9'h004,1'b0,1'b0,9'h000};
    tbl[3]  = '{1'b1,1'b1,1'b1,9'h008,1'b0,1'b1,9'h000};
    tbl[4]  = '{1'b1,1'b1,1'b1,9'h00C,1'b0,1'b1,9'h004};
    tbl[5]  = '{1'b1,1'b0,1'b0,9'h000,1'b1,1'b1,9'h008};
    tbl[6]  = '{1'b1,1'b0,1'b0,9'h000,1'b1,1'b1,9'h008};
    tbl[7]  = '{1'b0,1'b1,1'b1,9'h010,1'b1,1'b1,9'h008};
    tbl[8]  = '{1'b0,1'b1,1'b1,9'h010,1'b1,1'b1,9'h00C};
    tbl[9]  = '{1'b0,1'b1,1'b1,9'h010,1'b1,1'b0,9'h000};
    tbl[10] = '{1'b1,1'b1,1'b1,9'h010,1'b0,1'b0,9'h000};
    tbl[11] = '{1'b1,1'b1,1'b1,9'h014,1'b0,1'b0,9'h000};
    tbl[12] = '{1'b1,1'b1,1'b1,9'h018,1'b0,1'b1,9'h010};
    tbl[13] = '{1'b1,1'b1,1'b1,9'h01C,1'b0,1'b1,9'h014};

    rst             = 1'b0;
    pc              = '0;
    flush           = 1'b0;
    inst_ready      = 1'b0;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    #3;
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_stall", 32'(fetch_stall), 32'd1);
    chk("rst_ivalid", 32'(inst_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].g, tbl[i].r, 1'b1, 1'b0,
           tbl[i].req, tbl[i].a, tbl[i].s,
           tbl[i].v, tbl[i].ip);
    end

    // flush with two reads in flight
    hs(1,1,0,0, 1,9'h020, 1,9'h018);
    hs(1,1,0,1, 0,9'h000, 0,9'h000);
    pc = 9'h040;
    hs(1,1,1,0, 0,9'h000, 0,9'h000);
    hs(1,1,1,0, 0,9'h000, 0,9'h000);
    hs(1,1,1,0, 1,9'h040, 0,9'h000);
    hs(1,1,1,0, 1,9'h044, 0,9'h000);
    hs(1,1,1,0, 1,9'h048, 1,9'h040);

    // flush coincident with gnt and rvalid, one in flight
    hs(1,1,1,1, 0,9'h000, 1,9'h044);
    pc = 9'h080;
    hs(1,1,1,0, 1,9'h080, 0,9'h000);
    hs(1,1,1,0, 1,9'h084, 0,9'h000);
    hs(1,1,1,0, 1,9'h088, 1,9'h080);
    hs(1,1,0,0, 1,9'h08C, 1,9'h084);

    // flush with rvalid, two in flight: one left to drop
    hs(1,1,1,1, 0,9'h000, 0,9'h000);
    pc = 9'h0C0;
    hs(1,1,1,0, 0,9'h000, 0,9'h000);
    hs(1,1,1,0, 1,9'h0C0, 0,9'h000);
    hs(1,1,1,0, 1,9'h0C4, 0,9'h000);
    hs(1,1,1,0, 1,9'h0C8, 1,9'h0C0);
    hs(1,1,0,0, 1,9'h0CC, 1,9'h0C4);

    // reset mid-stream with two reads in flight
    bus.imem_gnt    = 1'b1;
    inst_ready      = 1'b1;
    flush           = 1'b0;
    bus.imem_rvalid = 1'b0;
    #1;
    rst = 1'b0;
    #1;
    chk("mrst_req", 32'(bus.imem_req), 32'd0);
    chk("mrst_adrx", 32'(bus.imem_adrx), 32'd0);
    chk("mrst_stall", 32'(fetch_stall), 32'd1);
    chk("mrst_ivalid", 32'(inst_valid), 32'd0);
    chk("mrst_inst", inst, 32'd0);
    chk("mrst_ipc", 32'(inst_pc), 32'd0);
    pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc++;

    // stale responses arrive after release
    hs(1,1,1,0, 0,9'h000, 0,9'h000);
    hs(1,1,1,0, 1,9'h000, 0,9'h000);
    hs(1,1,1,0, 1,9'h004, 0,9'h000);
    hs(1,1,1,0, 1,9'h008, 1,9'h000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
